// File: rtl/udp_payload_extractor.sv
// udp_payload_extractor: delimits CDC byte frames by idle gaps, validates Ethernet II/IPv4/UDP
// headers and forwards only the UDP payload with SOP/EOP framing.
module udp_payload_extractor #(
  parameter int GAP_CYCLES = 8,
  parameter logic [15:0] UDP_PORT = 16'd26400
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic [7:0]  dataIn,
  input  logic        dataValidIn,
  input  logic        dataErrIn,
  output logic [7:0]  payloadDataOut,
  output logic        payloadValidOut,
  output logic        payloadSopOut,
  output logic        payloadEopOut,
  output logic        payloadAbortOut,
  output logic        frameDropOut,
  output logic [15:0] dropCntOut
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [2:0] IDLE = 3'd0, ETH = 3'd1, IP = 3'd2, UDP = 3'd3, PAY = 3'd4, TAIL = 3'd5, DROP = 3'd6;

  logic [2:0]    state;
  logic [GW-1:0] gapCnt;
  logic [5:0]    off;
  logic [15:0]   len, payCnt;
  logic          first;
  logic          gapNow, gapSat, inHdr, hdrBad, startCyc, dropEv, abortEv, byteOk;

  always_comb begin
    gapNow   = !dataValidIn && gapCnt == GW'(GAP_CYCLES - 1);
    gapSat   = gapCnt == GW'(GAP_CYCLES);
    byteOk   = dataValidIn && !dataErrIn;
    inHdr    = state == ETH || state == IP || state == UDP;
    // a truncation drop leaves the counter saturated, so that cycle may already start a new frame
    startCyc = state == IDLE || (state == DROP && gapSat);
    hdrBad   = (off == 6'd12 && dataIn != 8'h08) || (off == 6'd13 && dataIn != 8'h00) ||
               (off == 6'd14 && dataIn != 8'h45) || (off == 6'd23 && dataIn != 8'h11) ||
               (off == 6'd36 && dataIn != UDP_PORT[15:8]) || (off == 6'd37 && dataIn != UDP_PORT[7:0]) ||
               (off == 6'd39 && {len[15:8], dataIn} < 16'd9);
    abortEv  = state == PAY && (gapNow || (dataValidIn && dataErrIn));
    dropEv   = abortEv || (startCyc && dataValidIn && dataErrIn) ||
               (inHdr && (gapNow || (dataValidIn && (dataErrIn || hdrBad))));
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state           <= IDLE;
      gapCnt          <= '0;
      off             <= '0;
      len             <= '0;
      payCnt          <= '0;
      first           <= 1'b0;
      payloadDataOut  <= 8'h00;
      payloadValidOut <= 1'b0;
      payloadSopOut   <= 1'b0;
      payloadEopOut   <= 1'b0;
      payloadAbortOut <= 1'b0;
      frameDropOut    <= 1'b0;
      dropCntOut      <= '0;
    end else begin
      payloadValidOut <= 1'b0;
      payloadSopOut   <= 1'b0;
      payloadEopOut   <= 1'b0;
      payloadAbortOut <= abortEv;
      frameDropOut    <= dropEv;
      gapCnt          <= dataValidIn ? '0 : gapSat ? gapCnt : gapCnt + 1'b1;
      if (dropEv && dropCntOut != 16'hFFFF) dropCntOut <= dropCntOut + 16'd1;
      case (state)
        IDLE, DROP: begin
          if (startCyc && dataValidIn) begin
            state <= dataErrIn ? DROP : ETH;
            off   <= 6'd1;
          end else if (state == DROP && (gapNow || gapSat)) state <= IDLE;
        end
        ETH, IP, UDP: begin
          if (dropEv) state <= DROP;
          else if (byteOk) begin
            off <= off + 6'd1;
            if (off == 6'd38) len[15:8] <= dataIn;
            if (off == 6'd39) len[7:0] <= dataIn;
            if (off == 6'd41) begin
              payCnt <= len - 16'd8;
              first  <= 1'b1;
            end
            state <= off == 6'd13 ? IP : off == 6'd33 ? UDP : off == 6'd41 ? PAY : state;
          end
        end
        PAY: begin
          if (dropEv) state <= gapNow ? IDLE : DROP;
          else if (byteOk) begin
            payloadDataOut  <= dataIn;
            payloadValidOut <= 1'b1;
            payloadSopOut   <= first;
            payloadEopOut   <= payCnt == 16'd1;
            payCnt          <= payCnt - 16'd1;
            first           <= 1'b0;
            if (payCnt == 16'd1) state <= TAIL;
          end
        end
        TAIL: if (gapNow) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_payload_extractor.sv
// tb_udp_payload_extractor: frame-level table and random tests against a datagram reference model.
module tb_udp_payload_extractor;
  localparam int GAP_CYCLES = 8;
  localparam logic [15:0] UDP_PORT = 16'd26400;

  logic        clkIn = 1'b0, rstIn = 1'b1;
  logic [7:0]  dataIn = 8'h00;
  logic        dataValidIn = 1'b0, dataErrIn = 1'b0;
  logic [7:0]  payloadDataOut;
  logic        payloadValidOut, payloadSopOut, payloadEopOut, payloadAbortOut, frameDropOut;
  logic [15:0] dropCntOut;

  udp_payload_extractor #(.GAP_CYCLES(GAP_CYCLES), .UDP_PORT(UDP_PORT)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .dataIn(dataIn), .dataValidIn(dataValidIn), .dataErrIn(dataErrIn),
    .payloadDataOut(payloadDataOut), .payloadValidOut(payloadValidOut), .payloadSopOut(payloadSopOut),
    .payloadEopOut(payloadEopOut), .payloadAbortOut(payloadAbortOut), .frameDropOut(frameDropOut),
    .dropCntOut(dropCntOut)
  );

  always #5 clkIn = ~clkIn;

  typedef struct { logic [7:0] d; logic sop, eop; int cyc; } exp_t;
  typedef struct {
    logic [15:0] et; logic [7:0] ver, proto; logic [15:0] port, len;
    int n, err, space; logic [31:0] head; int eOut, eDrop, eAbort;
  } vec_t;

  exp_t expQ[$];
  exp_t e;
  logic [7:0] fb [256];
  int fLen, errIdx, cyc = 0, vecs = 0, errs = 0;
  int outSeen = 0, dropSeen = 0, abortSeen = 0, modelDrops = 0;
  vec_t tbl [19];

  always @(posedge clkIn) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clkIn) if (!rstIn) begin
    if (payloadValidOut) begin
      outSeen++;
      if (expQ.size() != 0 && expQ[0].cyc == cyc) begin
        e = expQ.pop_front();
        chk("payload_data", 32'(payloadDataOut), 32'(e.d));
        chk("payload_sop", 32'(payloadSopOut), 32'(e.sop));
        chk("payload_eop", 32'(payloadEopOut), 32'(e.eop));
      end else chk("spurious_valid", 32'(payloadValidOut), 0);
    end else begin
      if (payloadSopOut || payloadEopOut) chk("strobe_without_valid", {30'b0, payloadSopOut, payloadEopOut}, 0);
      if (expQ.size() != 0 && expQ[0].cyc <= cyc) begin
        void'(expQ.pop_front());
        chk("missing_valid", 32'(payloadValidOut), 1);
      end
    end
    if (frameDropOut) dropSeen++;
    if (payloadAbortOut) abortSeen++;
  end

  task automatic build(input logic [15:0] et, input logic [7:0] ver, proto, input logic [15:0] port, len,
                       input int n, err, input logic [31:0] head);
    for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
    {fb[12], fb[13]} = et;
    fb[14] = ver;
    fb[23] = proto;
    {fb[36], fb[37]} = port;
    {fb[38], fb[39]} = len;
    {fb[42], fb[43], fb[44], fb[45]} = head;
    fLen = n;
    errIdx = err;
  endtask

  // Datagram view: a clean header delivers bytes 42.. up to L-8 of them, cut short by error or truncation.
  task automatic model(output bit ok, output int p, nOut, drop, abort);
    int endI;
    ok = fLen >= 42 && !(errIdx >= 0 && errIdx < 42) && {fb[12], fb[13]} == 16'h0800 && fb[14] == 8'h45 &&
         fb[23] == 8'h11 && {fb[36], fb[37]} == UDP_PORT && {fb[38], fb[39]} >= 16'd9;
    p = ok ? int'({fb[38], fb[39]}) - 8 : 0;
    endI = (errIdx >= 42 && errIdx < fLen) ? errIdx : fLen;
    nOut = !ok ? 0 : (endI >= 42 + p ? p : endI - 42);
    drop = (!ok || nOut < p) ? 1 : 0;
    abort = (ok && nOut < p) ? 1 : 0;
  endtask

  task automatic driveFrame(input int space, gap, input bit doChk, input int eOut, eDrop, eAbort);
    bit ok;
    int p, nOut, drop, abort, o0, d0, a0;
    model(ok, p, nOut, drop, abort);
    o0 = outSeen; d0 = dropSeen; a0 = abortSeen;
    for (int i = 0; i < fLen; i++) begin
      @(posedge clkIn); #1;
      dataValidIn = 1'b1; dataIn = fb[i]; dataErrIn = (i == errIdx);
      if (ok && i >= 42 && i < 42 + nOut) expQ.push_back('{fb[i], i == 42, i == 41 + p, cyc + 1});
      for (int s = 1; s < space; s++) begin
        @(posedge clkIn); #1;
        dataValidIn = 1'b0; dataErrIn = 1'b0; dataIn = 8'($urandom);
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clkIn); #1;
      dataValidIn = 1'b0; dataErrIn = 1'b0;
    end
    modelDrops += drop;
    if (doChk) begin
      repeat (2) @(posedge clkIn);
      @(negedge clkIn); #1;
      chk("out_count", 32'(outSeen - o0), 32'(nOut));
      chk("drop_pulses", 32'(dropSeen - d0), 32'(drop));
      chk("abort_pulses", 32'(abortSeen - a0), 32'(abort));
      chk("drop_cnt", 32'(dropCntOut), 32'(modelDrops));
      if (eOut >= 0) begin
        chk("tbl_out_count", 32'(outSeen - o0), 32'(eOut));
        chk("tbl_drop_pulses", 32'(dropSeen - d0), 32'(eDrop));
        chk("tbl_abort_pulses", 32'(abortSeen - a0), 32'(eAbort));
      end
    end
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, "_data"}, 32'(payloadDataOut), 0);
    chk({tag, "_valid"}, 32'(payloadValidOut), 0);
    chk({tag, "_sop"}, 32'(payloadSopOut), 0);
    chk({tag, "_eop"}, 32'(payloadEopOut), 0);
    chk({tag, "_abort"}, 32'(payloadAbortOut), 0);
    chk({tag, "_drop"}, 32'(frameDropOut), 0);
    chk({tag, "_dropcnt"}, 32'(dropCntOut), 0);
  endtask

  initial begin
    int o0, kind, ln, n;
    logic [15:0] et, port, len;
    logic [7:0] ver, proto;
    tbl[0]  = '{16'h0800, 8'h45, 8'h11, 16'd26400, 16'd12, 50, -1, 2, 32'hDEADBEEF, 4, 0, 0};
    tbl[1]  = '{16'h0800, 8'h45, 8'h11, 16'd26401, 16'd12, 50, -1, 2, 32'hDEADBEEF, 0, 1, 0};
    tbl[2]  = '{16'h0800, 8'h45, 8'h11, 16'd26400, 16'd12, 50, -1, 2, 32'hCAFEF00D, 4, 0, 0};
    tbl[3]  = '{16'h0800, 8'h45, 8'h11, 16'd26400, 16'd9, 47, -1, 2, 32'h5A000000, 1, 0, 0};
    tbl[4]  = '{16'h0800, 8'h45, 8'h11, 16'd26400, 16'd12, 50, 44, 2, 32'h01020304, 2, 1, 1};
    tbl[5]  = '{16'h0800, 8'h45, 8'h11, 16'd26400, 16'd12, 20, -1, 2, 32'h0, 0, 1, 0};
    tbl[6]  = '{16'h0800, 8'h45, 8'h11, 16'd26400, 16'd12, 50, -1, 1, 32'h11223344, 4, 0, 0};
    tbl[7]  = '{16'h86DD, 8'h45, 8'h11, 16'd26400, 16'd12, 50, -1, 2, 32'h0, 0, 1, 0};
    tbl[8]  = '{16'h0800, 8'h46, 8'h11, 16'd26400, 16'd12, 50, -1, 2, 32'h0, 0, 1, 0};
    tbl[9]  = '{16'h0800, 8'h45, 8'h06, 16'd26400, 16'd12, 50, -1, 2, 32'h0, 0, 1, 0};
    tbl[10] = '{16'h0800, 8'h45, 8'h11, 16'd26400, 16'd8, 50, -1, 2, 32'h0, 0, 1, 0};
    tbl[11] = '{16'h0800, 8'h45, 8'h11, 16'd26400, 16'd20, 48, -1, 2, 32'hA1A2A3A4, 6, 1, 1};
    tbl[12] = '{16'h0800, 8'h45, 8'h11, 16'd26400, 16'd12, 50, 47, 2, 32'hB1B2B3B4, 4, 0, 0};
    tbl[13] = '{16'h0800, 8'h45, 8'h11, 16'd26400, 16'd12, 50, 5, 2, 32'h0, 0, 1, 0};
    tbl[14] = '{16'h0800, 8'h45, 8'h11, 16'd26400, 16'd12, 50, 0, 2, 32'h0, 0, 1, 0};
    tbl[15] = '{16'h0800, 8'h45, 8'h11, 16'd26400, 16'd30, 68, -1, 1, 32'hC1C2C3C4, 22, 0, 0};
    tbl[16] = '{16'h0800, 8'h45, 8'h11, 16'd26400, 16'd9, 43, -1, 2, 32'h77000000, 1, 0, 0};
    tbl[17] = '{16'h0800, 8'h45, 8'h11, 16'd26400, 16'd12, 42, -1, 2, 32'h0, 0, 1, 1};
    tbl[18] = '{16'h0800, 8'h45, 8'h11, 16'd26400, 16'h0105, 50, -1, 2, 32'hD1D2D3D4, 8, 1, 1};

    repeat (3) @(posedge clkIn);
    #2 chkResetOutputs("reset");
    #1 rstIn = 1'b0;

    foreach (tbl[i]) begin
      build(tbl[i].et, tbl[i].ver, tbl[i].proto, tbl[i].port, tbl[i].len, tbl[i].n, tbl[i].err, tbl[i].head);
      driveFrame(tbl[i].space, GAP_CYCLES + 2, 1'b1, tbl[i].eOut, tbl[i].eDrop, tbl[i].eAbort);
    end

    for (int r = 0; r < 60; r++) begin
      et = 16'h0800; ver = 8'h45; proto = 8'h11; port = UDP_PORT;
      ln = $urandom_range(9, 30);
      len = 16'(ln);
      n = 42 + ln - 8 + $urandom_range(0, 4);
      kind = $urandom_range(0, 11);
      if (kind == 0) et = 16'h0800 ^ (16'h1 << $urandom_range(0, 15));
      if (kind == 1) ver = 8'h45 ^ (8'h1 << $urandom_range(0, 7));
      if (kind == 2) proto = 8'h11 ^ (8'h1 << $urandom_range(0, 7));
      if (kind == 3) port = UDP_PORT ^ (16'h1 << $urandom_range(0, 15));
      if (kind == 4) len = 16'($urandom_range(0, 8));
      if (kind == 6) n = $urandom_range(1, n - 1);
      build(et, ver, proto, port, len, n, kind == 5 ? int'($urandom_range(0, n - 1)) : -1, $urandom);
      driveFrame($urandom_range(1, 4), GAP_CYCLES + $urandom_range(0, 3), 1'b1, -1, -1, -1);
    end

    o0 = outSeen;
    build(16'h0800, 8'h45, 8'h11, UDP_PORT, 16'd12, 50, -1, 32'h10203040);
    driveFrame(1, GAP_CYCLES, 1'b0, -1, -1, -1);
    build(16'h0800, 8'h45, 8'h11, UDP_PORT, 16'd10, 46, -1, 32'h50607080);
    driveFrame(1, GAP_CYCLES, 1'b1, 2, 0, 0);
    chk("b2b_total_out", 32'(outSeen - o0), 6);

    build(16'h0800, 8'h45, 8'h11, UDP_PORT, 16'd12, 44, -1, 32'h90A0B0C0);
    driveFrame(1, 0, 1'b0, -1, -1, -1);
    @(posedge clkIn); #1;
    chk("pre_reset_valid", 32'(payloadValidOut), 1);
    #1 rstIn = 1'b1;
    #1 chkResetOutputs("midframe_reset");
    expQ.delete();
    modelDrops = 0;
    dataValidIn = 1'b0; dataErrIn = 1'b0;
    repeat (2) @(posedge clkIn);
    #3 rstIn = 1'b0;
    build(16'h0800, 8'h45, 8'h11, UDP_PORT, 16'd12, 50, -1, 32'hFEEDFACE);
    driveFrame(2, GAP_CYCLES + 2, 1'b1, 4, 0, 0);

    chk("leftover_expected", 32'(expQ.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
